gcn: RTL and testbench

// - Streaming graph-convolution engine: loads weights W, node features X and an edge list over a 16-bit word port.
// - Computes OUT = A_hat * (X * W), where A_hat = adjacency plus self-loops.
// - Each job produces two output columns. Successive jobs cover columns 0/1, 2/3, 4/5, 6/7, then wrap to 0/1.
// - Sits behind a host that streams one word per clock and reads the result column-serially.
//

---
 rtl/gcn.sv | 242 ++++++++++++++++++++++++
 tb/tb_gcn.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gcn.sv
// Streaming graph-convolution engine: OUT = (A + I) * (X * W) for two output columns per job.
// Loads W, X and an edge list over a 16-bit word port, then streams results column-serially.
module gcn #(
    parameter int unsigned N_MAX = 100,
    parameter int unsigned F     = 16,
    parameter int unsigned C     = 8,
    parameter int unsigned DW    = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic i_cmd,
    input  logic i_p0, i_p1, i_p2, i_p3, i_p4, i_p5, i_p6, i_p7,
    input  logic i_p8, i_p9, i_p10, i_p11, i_p12, i_p13, i_p14, i_p15,
    output logic o_rdy,
    output logic o_result,
    output logic o_p0, o_p1, o_p2, o_p3, o_p4, o_p5, o_p6, o_p7,
    output logic o_p8, o_p9, o_p10, o_p11, o_p12, o_p13, o_p14, o_p15
);

    localparam int unsigned NW = $clog2(N_MAX + 1);
    localparam int unsigned OW = NW + 1;
    localparam int unsigned FW = $clog2(F);
    localparam int unsigned CW = $clog2(C);
    localparam int unsigned JW = CW - 1;
    localparam int unsigned HW = DW / 2;

    typedef enum logic [2:0] {
        StIdle, StHdr, StLoadW, StLoadX, StEdge, StFin, StOut
    } state_e;

    logic [DW-1:0] p_in;
    assign p_in = {i_p15, i_p14, i_p13, i_p12, i_p11, i_p10, i_p9, i_p8,
                   i_p7, i_p6, i_p5, i_p4, i_p3, i_p2, i_p1, i_p0};

    state_e            state_q, state_d;
    logic [NW-1:0]     n_q, n_d;
    logic [DW-1:0]     e_q, e_d;
    logic [DW-1:0]     ecnt_q, ecnt_d;
    logic [FW+CW-1:0]  wcnt_q, wcnt_d;
    logic [FW-1:0]     fcnt_q, fcnt_d;
    logic [NW-1:0]     vcnt_q, vcnt_d;
    logic [DW-1:0]     sum_a_q, sum_a_d, sum_b_q, sum_b_d;
    logic [OW-1:0]     ocnt_q, ocnt_d;
    logic [JW-1:0]     job_q, job_d;
    logic              o_rdy_q, o_rdy_d, o_result_q, o_result_d;
    logic [DW-1:0]     o_p_q, o_p_d;

    logic [DW-1:0] w_a_q   [F];
    logic [DW-1:0] w_b_q   [F];
    logic [DW-1:0] xw_a_q  [N_MAX];
    logic [DW-1:0] xw_b_q  [N_MAX];
    logic [DW-1:0] acc_a_q [N_MAX];
    logic [DW-1:0] acc_b_q [N_MAX];

    logic          w_we_a, w_we_b, xw_we, acc_we;
    logic [FW-1:0] w_addr;
    logic [NW-1:0] acc_addr;
    logic [DW-1:0] acc_wa, acc_wb;

    logic [CW-1:0] col_a, col_b, w_col;
    logic [DW-1:0] prod_a, prod_b, xw_a_new, xw_b_new, out_word;
    logic [HW-1:0] e_src, e_dst;
    logic          e_ok;
    logic [OW-1:0] ob_idx;

    assign col_a    = {job_q, 1'b0};
    assign col_b    = {job_q, 1'b1};
    assign w_col    = wcnt_q[CW-1:0];
    assign prod_a   = p_in * w_a_q[fcnt_q];
    assign prod_b   = p_in * w_b_q[fcnt_q];
    assign xw_a_new = sum_a_q + prod_a;
    assign xw_b_new = sum_b_q + prod_b;
    assign e_src    = p_in[HW-1:0];
    assign e_dst    = p_in[DW-1:HW];
    assign e_ok     = i_cmd && (e_src < HW'(n_q)) && (e_dst < HW'(n_q));
    assign ob_idx   = ocnt_q - {1'b0, n_q} - OW'(1);

    // Result stream: words 1..N are column a, N+1..2N column b.
    always_comb begin
        if (ocnt_q <= {1'b0, n_q}) begin
            out_word = acc_a_q[ocnt_q[NW-1:0] - NW'(1)];
        end else begin
            out_word = acc_b_q[ob_idx[NW-1:0]];
        end
    end

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        e_d      = e_q;
        ecnt_d   = ecnt_q;
        wcnt_d   = wcnt_q;
        fcnt_d   = fcnt_q;
        vcnt_d   = vcnt_q;
        sum_a_d  = sum_a_q;
        sum_b_d  = sum_b_q;
        ocnt_d   = ocnt_q;
        job_d    = job_q;
        o_rdy_d  = o_rdy_q;
        o_p_d    = o_p_q;
        w_we_a   = 1'b0;
        w_we_b   = 1'b0;
        w_addr   = wcnt_q[FW+CW-1:CW];
        xw_we    = 1'b0;
        acc_we   = 1'b0;
        acc_addr = vcnt_q;
        acc_wa   = xw_a_new;
        acc_wb   = xw_b_new;

        unique case (state_q)
            StIdle: begin
                if (i_req) begin
                    n_d     = (p_in[HW-1:0] > HW'(N_MAX)) ? NW'(N_MAX) : NW'(p_in[HW-1:0]);
                    state_d = StHdr;
                end
            end
            StHdr: begin
                e_d     = p_in;
                ecnt_d  = '0;
                wcnt_d  = '0;
                state_d = StLoadW;
            end
            StLoadW: begin
                w_we_a = (w_col == col_a);
                w_we_b = (w_col == col_b);
                wcnt_d = wcnt_q + (FW+CW)'(1);
                if (wcnt_q == (FW+CW)'(F * C - 1)) begin
                    fcnt_d  = '0;
                    vcnt_d  = '0;
                    sum_a_d = '0;
                    sum_b_d = '0;
                    if (n_q == '0) begin
                        state_d = (e_q == '0) ? StFin : StEdge;
                    end else begin
                        state_d = StLoadX;
                    end
                end
            end
            StLoadX: begin
                fcnt_d  = fcnt_q + FW'(1);
                sum_a_d = xw_a_new;
                sum_b_d = xw_b_new;
                // End of a row: store XW and seed ACC with the self-loop term.
                if (fcnt_q == FW'(F - 1)) begin
                    xw_we   = 1'b1;
                    acc_we  = 1'b1;
                    sum_a_d = '0;
                    sum_b_d = '0;
                    vcnt_d  = vcnt_q + NW'(1);
                    if (vcnt_q == n_q - NW'(1)) begin
                        state_d = (e_q == '0) ? StFin : StEdge;
                    end
                end
            end
            StEdge: begin
                ecnt_d   = ecnt_q + DW'(1);
                acc_addr = e_dst[NW-1:0];
                acc_wa   = acc_a_q[e_dst[NW-1:0]] + xw_a_q[e_src[NW-1:0]];
                acc_wb   = acc_b_q[e_dst[NW-1:0]] + xw_b_q[e_src[NW-1:0]];
                acc_we   = e_ok;
                if (ecnt_q == e_q - DW'(1)) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                state_d = StOut;
                o_rdy_d = 1'b1;
                o_p_d   = {HW'(col_b), HW'(col_a)};
                ocnt_d  = OW'(1);
            end
            StOut: begin
                if (ocnt_q == {n_q, 1'b1}) begin
                    o_rdy_d = 1'b0;
                    o_p_d   = '0;
                    job_d   = job_q + JW'(1);
                    state_d = StIdle;
                end else begin
                    o_p_d  = out_word;
                    ocnt_d = ocnt_q + OW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        o_result_d = (state_d == StFin);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            n_q        <= '0;
            e_q        <= '0;
            ecnt_q     <= '0;
            wcnt_q     <= '0;
            fcnt_q     <= '0;
            vcnt_q     <= '0;
            sum_a_q    <= '0;
            sum_b_q    <= '0;
            ocnt_q     <= '0;
            job_q      <= '0;
            o_rdy_q    <= 1'b0;
            o_result_q <= 1'b0;
            o_p_q      <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            e_q        <= e_d;
            ecnt_q     <= ecnt_d;
            wcnt_q     <= wcnt_d;
            fcnt_q     <= fcnt_d;
            vcnt_q     <= vcnt_d;
            sum_a_q    <= sum_a_d;
            sum_b_q    <= sum_b_d;
            ocnt_q     <= ocnt_d;
            job_q      <= job_d;
            o_rdy_q    <= o_rdy_d;
            o_result_q <= o_result_d;
            o_p_q      <= o_p_d;
        end
    end

    // Buffers carry no reset; their contents are rebuilt by every job.
    always_ff @(posedge clk) begin
        if (w_we_a) w_a_q[w_addr] <= p_in;
        if (w_we_b) w_b_q[w_addr] <= p_in;
        if (xw_we) begin
            xw_a_q[vcnt_q] <= xw_a_new;
            xw_b_q[vcnt_q] <= xw_b_new;
        end
        if (acc_we) begin
            acc_a_q[acc_addr] <= acc_wa;
            acc_b_q[acc_addr] <= acc_wb;
        end
    end

    assign o_rdy    = o_rdy_q;
    assign o_result = o_result_q;
    assign {o_p15, o_p14, o_p13, o_p12, o_p11, o_p10, o_p9, o_p8,
            o_p7, o_p6, o_p5, o_p4, o_p3, o_p2, o_p1, o_p0} = o_p_q;

endmodule

// File: tb/tb_gcn.sv
// Self-checking bench for gcn: table of uniform jobs plus directed edge, overflow,
// mid-load reset and full-size randomised jobs checked against a matrix model.
module tb_gcn;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0;
    logic        i_cmd = 1'b0;
    logic [15:0] din = 16'h0;
    wire         o_rdy, o_result;
    wire  [15:0] dout;

    gcn dut (
        .clk(clk), .rst(rst), .i_req(i_req), .i_cmd(i_cmd),
        .i_p0(din[0]), .i_p1(din[1]), .i_p2(din[2]), .i_p3(din[3]),
        .i_p4(din[4]), .i_p5(din[5]), .i_p6(din[6]), .i_p7(din[7]),
        .i_p8(din[8]), .i_p9(din[9]), .i_p10(din[10]), .i_p11(din[11]),
        .i_p12(din[12]), .i_p13(din[13]), .i_p14(din[14]), .i_p15(din[15]),
        .o_rdy(o_rdy), .o_result(o_result),
        .o_p0(dout[0]), .o_p1(dout[1]), .o_p2(dout[2]), .o_p3(dout[3]),
        .o_p4(dout[4]), .o_p5(dout[5]), .o_p6(dout[6]), .o_p7(dout[7]),
        .o_p8(dout[8]), .o_p9(dout[9]), .o_p10(dout[10]), .o_p11(dout[11]),
        .o_p12(dout[12]), .o_p13(dout[13]), .o_p14(dout[14]), .o_p15(dout[15])
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [15:0] wm [16][8];
    logic [15:0] xm [100][16];
    logic [15:0] em [1024];
    logic [15:0] got [202];
    int          got_n;
    logic [15:0] exp_a [100];
    logic [15:0] exp_b [100];

    typedef struct {
        int          n;
        logic [15:0] wv;
        logic [15:0] wstep;
        logic [15:0] xv;
        logic [15:0] hdr;
        logic [15:0] va;
        logic [15:0] vb;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic req, input logic cmd, input logic [15:0] d);
        i_req = req;
        i_cmd = cmd;
        din   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_job(input int hdr_n, input int nn, input int ee, input bit noise);
        logic r;
        send(1'b1, 1'b0, {8'hA5, 8'(hdr_n)});
        send(1'b1, 1'b0, 16'(ee));
        for (int f = 0; f < 16; f++)
            for (int c = 0; c < 8; c++) begin
                r = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                send(r, 1'b0, wm[f][c]);
            end
        for (int v = 0; v < nn; v++)
            for (int f = 0; f < 16; f++) begin
                r = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                send(r, 1'b0, xm[v][f]);
            end
        for (int i = 0; i < ee; i++) begin
            r = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            send(r, 1'b1, em[i]);
        end
        i_req = 1'b0;
        i_cmd = 1'b0;
        din   = 16'h0;
    endtask

    // Called right after the last job word: expects one FIN cycle, then the OUT burst.
    task automatic collect(input string tag, input int nn);
        logic busy_seen;
        for (int i = 0; i < 202; i++) got[i] = 16'hxxxx;
        check({tag, " fin o_result"}, 32'(o_result), 32'd1);
        check({tag, " fin o_rdy"}, 32'(o_rdy), 32'd0);
        @(posedge clk);
        #1;
        got_n = 0;
        busy_seen = 1'b0;
        while (o_rdy === 1'b1 && got_n < 300) begin
            if (got_n < 202) got[got_n] = dout;
            if (o_result !== 1'b0) busy_seen = 1'b1;
            got_n++;
            @(posedge clk);
            #1;
        end
        check({tag, " rdy cycles"}, 32'(got_n), 32'(2 * nn + 1));
        check({tag, " out busy"}, 32'(busy_seen), 32'd0);
        check({tag, " o_p after"}, 32'(dout), 32'd0);
    endtask

    task automatic check_out(input string tag, input int nn, input logic [15:0] hdr);
        check({tag, " header"}, 32'(got[0]), 32'(hdr));
        for (int v = 0; v < nn; v++) begin
            check($sformatf("%s a[%0d]", tag, v), 32'(got[1 + v]), 32'(exp_a[v]));
            check($sformatf("%s b[%0d]", tag, v), 32'(got[1 + nn + v]), 32'(exp_b[v]));
        end
    endtask

    task automatic model(input int nn, input int ee, input int jb);
        logic [15:0] xa [100];
        logic [15:0] xb [100];
        logic [7:0]  s, d;
        for (int v = 0; v < nn; v++) begin
            xa[v] = 16'h0;
            xb[v] = 16'h0;
            for (int f = 0; f < 16; f++) begin
                xa[v] = xa[v] + 16'(xm[v][f] * wm[f][2 * jb]);
                xb[v] = xb[v] + 16'(xm[v][f] * wm[f][2 * jb + 1]);
            end
            exp_a[v] = xa[v];
            exp_b[v] = xb[v];
        end
        for (int i = 0; i < ee; i++) begin
            s = em[i][7:0];
            d = em[i][15:8];
            if (int'(s) < nn && int'(d) < nn) begin
                exp_a[d] = exp_a[d] + xa[s];
                exp_b[d] = exp_b[d] + xb[s];
            end
        end
    endtask

    task automatic clear_mats();
        for (int f = 0; f < 16; f++)
            for (int c = 0; c < 8; c++) wm[f][c] = 16'h0;
        for (int v = 0; v < 100; v++)
            for (int f = 0; f < 16; f++) xm[v][f] = 16'h0;
    endtask

    task automatic run_uniform(input string tag, input vec_t t);
        for (int f = 0; f < 16; f++)
            for (int c = 0; c < 8; c++) wm[f][c] = t.wv + 16'(c) * t.wstep;
        for (int v = 0; v < t.n; v++)
            for (int f = 0; f < 16; f++) xm[v][f] = t.xv;
        for (int v = 0; v < t.n; v++) begin
            exp_a[v] = t.va;
            exp_b[v] = t.vb;
        end
        drive_job(t.n, t.n, 0, 1'b0);
        collect(tag, t.n);
        check_out(tag, t.n, t.hdr);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl [5];
        tbl[0] = '{2, 16'h0001, 16'h0000, 16'h0001, 16'h0100, 16'h0010, 16'h0010};
        tbl[1] = '{1, 16'h0002, 16'h0001, 16'h0003, 16'h0302, 16'h00C0, 16'h00F0};
        tbl[2] = '{4, 16'hFFFF, 16'h0001, 16'h0005, 16'h0504, 16'h00F0, 16'h0140};
        tbl[3] = '{3, 16'h0100, 16'h0000, 16'h0100, 16'h0706, 16'h0000, 16'h0000};
        tbl[4] = '{2, 16'h0001, 16'h0000, 16'h0001, 16'h0100, 16'h0010, 16'h0010};

        // Reset and idle: stray i_req=0 words must not start anything.
        #3;
        check("reset o_rdy", 32'(o_rdy), 32'd0);
        check("reset o_result", 32'(o_result), 32'd0);
        check("reset o_p", 32'(dout), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        while ($time < 20) send(1'b0, 1'($urandom_range(0, 1)), 16'($urandom));
        send(1'b0, 1'b0, 16'h1234);
        check("idle o_rdy", 32'(o_rdy), 32'd0);
        check("idle o_result", 32'(o_result), 32'd0);
        check("idle o_p", 32'(dout), 32'd0);

        clear_mats();
        for (int i = 0; i < 5; i++) run_uniform($sformatf("tbl%0d", i), tbl[i]);

        // N=3 with edges 1->0, 2->0 and an out-of-range dst; XW[v] = v+1.
        clear_mats();
        for (int c = 0; c < 8; c++) wm[0][c] = 16'h0001;
        for (int v = 0; v < 3; v++) xm[v][0] = 16'(v + 1);
        em[0] = 16'h0001;
        em[1] = 16'h0002;
        em[2] = 16'h0500;
        exp_a[0] = 16'd6; exp_a[1] = 16'd2; exp_a[2] = 16'd3;
        exp_b[0] = 16'd6; exp_b[1] = 16'd2; exp_b[2] = 16'd3;
        drive_job(3, 3, 3, 1'b0);
        collect("edges", 3);
        check_out("edges", 3, 16'h0302);

        // Wrapping product and an edge with src=200.
        clear_mats();
        for (int f = 0; f < 16; f++)
            for (int c = 0; c < 8; c++) wm[f][c] = 16'h0002;
        xm[0][0] = 16'h7FFF;
        em[0] = 16'h00C8;
        exp_a[0] = 16'hFFFE;
        exp_b[0] = 16'hFFFE;
        drive_job(1, 1, 1, 1'b0);
        collect("ovf", 1);
        check_out("ovf", 1, 16'h0504);

        // Reset in the middle of the W load.
        send(1'b1, 1'b0, 16'h0002);
        send(1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 10; i++) send(1'b0, 1'b0, 16'h0003);
        rst = 1'b0;
        i_req = 1'b0;
        #2;
        check("midrst o_rdy", 32'(o_rdy), 32'd0);
        check("midrst o_result", 32'(o_result), 32'd0);
        check("midrst o_p", 32'(dout), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        clear_mats();
        run_uniform("postrst", tbl[0]);

        // Full-size job, random data, i_req noise during the load phases.
        for (int f = 0; f < 16; f++)
            for (int c = 0; c < 8; c++) wm[f][c] = 16'($urandom);
        for (int v = 0; v < 100; v++)
            for (int f = 0; f < 16; f++) xm[v][f] = 16'($urandom);
        for (int i = 0; i < 782; i++)
            em[i] = {8'($urandom_range(0, 104)), 8'($urandom_range(0, 104))};
        model(100, 782, 1);
        drive_job(100, 100, 782, 1'b1);
        collect("full", 100);
        check_out("full", 100, 16'h0302);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
